exe_mem_reg: RTL and testbench
==============================

# exe_mem_reg

EXE→MEM pipeline boundary register for the ARM core. It captures the ALU result, store data, destination register and memory/write-back controls at the end of the execute stage. It also owns the architectural status register {Z,C,N,V}, which feeds back to the ALU `sr_in` and to the condition-check logic in decode. It supports stall (freeze) and squash (flush) so hazard and branch logic can hold or kill the instruction in execute.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `REG_W`, 4, register-index width

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `valid_in`  in  1  execute stage holds a real instruction
- `alu_result`  in  DATA_W  ALU output
- `sr_alu`  in  4  ALU flags, order {Z,C,N,V}
- `s_bit`  in  1  instruction updates flags
- `val_rm`  in  DATA_W  store data for STR
- `dest`  in  REG_W  write-back register index
- `wb_en`, `mem_r_en`, `mem_w_en`  in  1 each  controls
- `pc_in`  in  DATA_W  instruction PC (debug)
- `freeze`  in  1  hold all state this cycle
- `flush`  in  1  squash the instruction in execute
- `valid_q`  out  1  MEM stage holds a real instruction
- `alu_result_q`, `val_rm_q`, `pc_q`  out  DATA_W  registered data
- `dest_q`  out  REG_W  registered destination
- `wb_en_q`, `mem_r_en_q`, `mem_w_en_q`  out  1 each  registered controls, already gated by `valid_q`
- `sr`  out  4  architectural status register {Z,C,N,V}
- `fwd_dest`, `fwd_wb_en`  out  REG_W / 1  copies of `dest_q` / `wb_en_q` for the hazard unit

## Operation
- Reset (`rst`=0, asynchronous) clears every register output to 0, including `sr`=4'b0000 and `valid_q`=0.
- Priority per edge: reset > flush > freeze > load.
- Load (no flush, no freeze):
  - all `_q` registers take their inputs.
  - `valid_q` <= `valid_in`.
  - Control outputs <= input & `valid_in`.
- Flush:
  - `valid_q`, `wb_en_q`, `mem_r_en_q` and `mem_w_en_q` go to 0.
  - Data registers hold their values (don't-care).
  - `sr` is not updated.
- Freeze without flush: every register, including `sr`, holds.
- Status register:
  - `sr` <= `sr_alu` only when `valid_in` & `s_bit` & ~`flush` & ~`freeze`; otherwise it holds.
  - A killed or stalled instruction never changes flags.
- Flush and freeze together: flush wins. The bubble is inserted and the stalled instruction is dropped.
- Invariant: a `_q` control bit is never 1 while `valid_q`=0.
- No arithmetic in this block; widths pass through unchanged.

## Timing
- Latency: 1 cycle from input to every `_q` output.
- An `sr` update is visible to the ALU `sr_in` on the cycle after the flag-setting instruction leaves execute. This allows back-to-back CMP→ADC without a stall.
- Outputs are purely registered. `fwd_*` are wires from registers, with no combinational path from inputs.
- Reset deassertion is synchronised externally. The first load occurs on the first edge with `rst`=1.

## Configuration
- `EXE_MEM_PERF_EN`
- Defined: adds outputs `perf_retired` (32 bit) and `perf_squashed` (32 bit). Both reset to 0.
  - `perf_retired` increments on each edge where an instruction is loaded with `valid_in`=1.
  - `perf_squashed` increments on each edge where `flush`=1 and `valid_in`=1.
  - Both hold under freeze without flush and wrap modulo 2^32.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `arm_pkg`:
  - flag index constants `SR_Z`=3, `SR_C`=2, `SR_N`=1, `SR_V`=0
  - `DATA_W` and `REG_W` defaults
  - a struct typedef for the EXE→MEM control bundle {`wb_en`, `mem_r_en`, `mem_w_en`, `dest`}
- One natural sub-module: `status_reg`, a 4-bit register with load enable and active-low asynchronous reset, instantiated for `sr`.
- The rest is flat.

## Test plan
- Reset: drive random inputs, then pulse `rst`=0 mid-cycle -> all outputs read 0 immediately, with no clock edge required.
- Load: `valid_in`=1, `alu_result`=0x0000_0010, `dest`=4'd5, `wb_en`=1 -> next cycle `alu_result_q`=0x10, `dest_q`=5, `wb_en_q`=1, `valid_q`=1.
- Flags: CMP with `sr_alu`=4'b1100, `s_bit`=1, then ADD with `s_bit`=0 and `sr_alu`=4'b0001 -> `sr`=4'b1100 after the first edge and stays 4'b1100 after the second.
- Freeze: load STR (`mem_w_en`=1, `val_rm`=0xDEAD_BEEF), then hold `freeze`=1 for 3 cycles with changing inputs and `s_bit`=1 -> all `_q` and `sr` unchanged.
- Flush priority: `flush`=1 and `freeze`=1 with `valid_in`=1, `wb_en`=1, `s_bit`=1, `sr_alu`=4'b0010 -> `valid_q`=0, `wb_en_q`=0, `sr` unchanged.
- With `EXE_MEM_PERF_EN`: 5 valid loads, 2 flushes and 1 freeze -> `perf_retired`=5, `perf_squashed`=2.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline: flag positions, default widths
// and the EXE->MEM control bundle.
package arm_pkg;

   localparam int DATA_W_DEFAULT = 32;
   localparam int REG_W_DEFAULT  = 4;

   // Bit positions inside the {Z,C,N,V} status register
   localparam int SR_Z = 3;
   localparam int SR_C = 2;
   localparam int SR_N = 1;
   localparam int SR_V = 0;

   typedef struct packed {
      logic                     wb_en;
      logic                     mem_r_en;
      logic                     mem_w_en;
      logic [REG_W_DEFAULT-1:0] dest;
   } exe_mem_ctrl_t;

   // Clears the side-effecting enables of a bundle unless it belongs to a live instruction
   function automatic exe_mem_ctrl_t gate_ctrl(input exe_mem_ctrl_t ctrl, input logic live);
      exe_mem_ctrl_t res;
      res          = ctrl;
      res.wb_en    = ctrl.wb_en & live;
      res.mem_r_en = ctrl.mem_r_en & live;
      res.mem_w_en = ctrl.mem_w_en & live;
      return res;
   endfunction

endpackage

// File: rtl/exe_mem_reg_status.sv
// Architectural {Z,C,N,V} status register: 4-bit register with load enable and
// asynchronous active-low reset.
module status_reg
   import arm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_en,
   input  logic [3:0] d,
   output logic [3:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 4'b0000;
      end else if (load_en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/exe_mem_reg.sv
// EXE->MEM pipeline register with stall/squash and the architectural flags.
// Optional performance counters are enabled by defining EXE_MEM_PERF_EN.
module exe_mem_reg
   import arm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int REG_W  = REG_W_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        sr_alu,
   input  logic              s_bit,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [REG_W-1:0]  dest,
   input  logic              wb_en,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              freeze,
   input  logic              flush,
   output logic              valid_q,
   output logic [DATA_W-1:0] alu_result_q,
   output logic [DATA_W-1:0] val_rm_q,
   output logic [DATA_W-1:0] pc_q,
   output logic [REG_W-1:0]  dest_q,
   output logic              wb_en_q,
   output logic              mem_r_en_q,
   output logic              mem_w_en_q,
   output logic [3:0]        sr,
   output logic [REG_W-1:0]  fwd_dest,
   output logic              fwd_wb_en
`ifdef EXE_MEM_PERF_EN
   ,
   output logic [31:0]       perf_retired,
   output logic [31:0]       perf_squashed
`endif
);

   exe_mem_ctrl_t ctrl_in;
   exe_mem_ctrl_t ctrl_q;
   logic          load;
   logic          sr_load;

   // The control bundle carries dest at the package's register-index width
   assign ctrl_in.wb_en    = wb_en;
   assign ctrl_in.mem_r_en = mem_r_en;
   assign ctrl_in.mem_w_en = mem_w_en;
   assign ctrl_in.dest     = dest;

   assign load    = ~flush & ~freeze;
   assign sr_load = valid_in & s_bit & load;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         ctrl_q       <= '0;
         alu_result_q <= '0;
         val_rm_q     <= '0;
         pc_q         <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= gate_ctrl(ctrl_q, 1'b0);
      end else if (!freeze) begin
         valid_q      <= valid_in;
         ctrl_q       <= gate_ctrl(ctrl_in, valid_in);
         alu_result_q <= alu_result;
         val_rm_q     <= val_rm;
         pc_q         <= pc_in;
      end
   end

   status_reg u_status_reg (
      .clk     (clk),
      .rst     (rst),
      .load_en (sr_load),
      .d       (sr_alu),
      .q       (sr)
   );

   assign dest_q     = ctrl_q.dest;
   assign wb_en_q    = ctrl_q.wb_en;
   assign mem_r_en_q = ctrl_q.mem_r_en;
   assign mem_w_en_q = ctrl_q.mem_w_en;
   assign fwd_dest   = ctrl_q.dest;
   assign fwd_wb_en  = ctrl_q.wb_en;

`ifdef EXE_MEM_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_retired  <= '0;
         perf_squashed <= '0;
      end else begin
         if (load && valid_in) begin
            perf_retired <= perf_retired + 32'd1;
         end
         if (flush && valid_in) begin
            perf_squashed <= perf_squashed + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// Scoreboard bench for exe_mem_reg: a rule-level model predicts the state after
// every edge and a negedge monitor compares it with the DUT outputs.
module tb_exe_mem_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] alu_result = '0;
   logic [3:0]  sr_alu = '0;
   logic        s_bit = 1'b0;
   logic [31:0] val_rm = '0;
   logic [3:0]  dest = '0;
   logic        wb_en = 1'b0;
   logic        mem_r_en = 1'b0;
   logic        mem_w_en = 1'b0;
   logic [31:0] pc_in = '0;
   logic        freeze = 1'b0;
   logic        flush = 1'b0;
   logic        valid_q;
   logic [31:0] alu_result_q;
   logic [31:0] val_rm_q;
   logic [31:0] pc_q;
   logic [3:0]  dest_q;
   logic        wb_en_q;
   logic        mem_r_en_q;
   logic        mem_w_en_q;
   logic [3:0]  sr;
   logic [3:0]  fwd_dest;
   logic        fwd_wb_en;
`ifdef EXE_MEM_PERF_EN
   logic [31:0] perf_retired;
   logic [31:0] perf_squashed;
`endif

   int checks = 0;
   int errors = 0;

   exe_mem_reg #(.DATA_W(32), .REG_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .alu_result   (alu_result),
      .sr_alu       (sr_alu),
      .s_bit        (s_bit),
      .val_rm       (val_rm),
      .dest         (dest),
      .wb_en        (wb_en),
      .mem_r_en     (mem_r_en),
      .mem_w_en     (mem_w_en),
      .pc_in        (pc_in),
      .freeze       (freeze),
      .flush        (flush),
      .valid_q      (valid_q),
      .alu_result_q (alu_result_q),
      .val_rm_q     (val_rm_q),
      .pc_q         (pc_q),
      .dest_q       (dest_q),
      .wb_en_q      (wb_en_q),
      .mem_r_en_q   (mem_r_en_q),
      .mem_w_en_q   (mem_w_en_q),
      .sr           (sr),
      .fwd_dest     (fwd_dest),
      .fwd_wb_en    (fwd_wb_en)
`ifdef EXE_MEM_PERF_EN
      ,
      .perf_retired (perf_retired),
      .perf_squashed(perf_squashed)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] rm;
      logic [31:0] pc;
      logic [3:0]  dest;
      logic        wb;
      logic        mr;
      logic        mw;
      logic [3:0]  flags;
      logic [31:0] retired;
      logic [31:0] squashed;
   } exp_t;

   exp_t m = '0;
   exp_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Architectural rules: reset clears, flush kills, freeze holds, otherwise load
   task automatic model_step();
      if (!rst) begin
         m = '0;
      end else if (flush) begin
         if (valid_in) m.squashed = m.squashed + 1;
         m.valid = 1'b0;
         m.wb    = 1'b0;
         m.mr    = 1'b0;
         m.mw    = 1'b0;
      end else if (!freeze) begin
         if (valid_in) m.retired = m.retired + 1;
         m.valid = valid_in;
         m.alu   = alu_result;
         m.rm    = val_rm;
         m.pc    = pc_in;
         m.dest  = dest;
         m.wb    = wb_en && valid_in;
         m.mr    = mem_r_en && valid_in;
         m.mw    = mem_w_en && valid_in;
         if (valid_in && s_bit) m.flags = sr_alu;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      sb_q.push_back(m);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] alu, input logic [3:0] fl,
                         input logic s, input logic [31:0] rm, input logic [3:0] d,
                         input logic wb, input logic mr, input logic mw,
                         input logic frz, input logic fsh);
      valid_in = v;  alu_result = alu; sr_alu = fl; s_bit = s; val_rm = rm;
      dest = d; wb_en = wb; mem_r_en = mr; mem_w_en = mw; freeze = frz; flush = fsh;
   endtask

   task automatic rand_in(input logic allow_stall);
      logic [31:0] r;
      r = $urandom;
      valid_in = r[0]; s_bit = r[1]; wb_en = r[2]; mem_r_en = r[3]; mem_w_en = r[4];
      dest = r[8:5]; sr_alu = r[12:9];
      flush  = allow_stall && (r[15:13] == 3'd0);
      freeze = allow_stall && (r[18:16] < 3'd2);
      alu_result = $urandom; val_rm = $urandom; pc_in = $urandom;
   endtask

   // Monitor: pops the prediction for the edge just taken and compares it
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("valid_q", {31'b0, valid_q}, {31'b0, e.valid});
            chk("wb_en_q", {31'b0, wb_en_q}, {31'b0, e.wb});
            chk("mem_r_en_q", {31'b0, mem_r_en_q}, {31'b0, e.mr});
            chk("mem_w_en_q", {31'b0, mem_w_en_q}, {31'b0, e.mw});
            chk("fwd_wb_en", {31'b0, fwd_wb_en}, {31'b0, e.wb});
            chk("sr", {28'b0, sr}, {28'b0, e.flags});
            if (e.valid) begin
               chk("alu_result_q", alu_result_q, e.alu);
               chk("val_rm_q", val_rm_q, e.rm);
               chk("pc_q", pc_q, e.pc);
               chk("dest_q", {28'b0, dest_q}, {28'b0, e.dest});
               chk("fwd_dest", {28'b0, fwd_dest}, {28'b0, e.dest});
            end
`ifdef EXE_MEM_PERF_EN
            chk("perf_retired", perf_retired, e.retired);
            chk("perf_squashed", perf_squashed, e.squashed);
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cycle();
      chk("reset_valid_q", {31'b0, valid_q}, 32'd0);
      chk("reset_sr", {28'b0, sr}, 32'd0);
      rst = 1'b1;

      // Load
      set_in(1'b1, 32'h0000_0010, 4'b0000, 1'b0, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("load_alu", alu_result_q, 32'h10);
      chk("load_dest", {28'b0, dest_q}, 32'd5);
      chk("load_wb", {31'b0, wb_en_q}, 32'd1);
      chk("load_valid", {31'b0, valid_q}, 32'd1);

      // Flags: CMP sets, ADD without S leaves them
      set_in(1'b1, 32'h0, 4'b1100, 1'b1, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("cmp_sr", {28'b0, sr}, 32'hC);
      set_in(1'b1, 32'h5, 4'b0001, 1'b0, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("add_sr", {28'b0, sr}, 32'hC);

      // Freeze holds a loaded STR and the flags
      set_in(1'b1, 32'h100, 4'b0000, 1'b0, 32'hDEAD_BEEF, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         rand_in(1'b0);
         valid_in = 1'b1; s_bit = 1'b1; freeze = 1'b1;
         cycle();
         chk("frz_mem_w", {31'b0, mem_w_en_q}, 32'd1);
         chk("frz_val_rm", val_rm_q, 32'hDEAD_BEEF);
         chk("frz_sr", {28'b0, sr}, 32'hC);
      end

      // Flush beats freeze
      set_in(1'b1, 32'h7, 4'b0010, 1'b1, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      cycle();
      chk("fl_valid", {31'b0, valid_q}, 32'd0);
      chk("fl_wb", {31'b0, wb_en_q}, 32'd0);
      chk("fl_sr", {28'b0, sr}, 32'hC);

      for (int i = 0; i < 300; i++) begin
         rand_in(1'b1);
         cycle();
      end

      // Asynchronous reset mid-cycle, no edge
      rand_in(1'b0);
      valid_in = 1'b1; wb_en = 1'b1; s_bit = 1'b1; sr_alu = 4'hF;
      cycle();
      sb_q.delete();
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", {31'b0, valid_q}, 32'd0);
      chk("arst_alu", alu_result_q, 32'd0);
      chk("arst_rm", val_rm_q, 32'd0);
      chk("arst_pc", pc_q, 32'd0);
      chk("arst_ctrl", {28'b0, wb_en_q, mem_r_en_q, mem_w_en_q, fwd_wb_en}, 32'd0);
      chk("arst_dest", {24'b0, dest_q, fwd_dest}, 32'd0);
      chk("arst_sr", {28'b0, sr}, 32'd0);
`ifdef EXE_MEM_PERF_EN
      chk("arst_perf", perf_retired | perf_squashed, 32'd0);
`endif
      m = '0;
      cycle();
      rst = 1'b1;

`ifdef EXE_MEM_PERF_EN
      for (int i = 0; i < 5; i++) begin
         rand_in(1'b0); valid_in = 1'b1;
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         rand_in(1'b0); valid_in = 1'b1; flush = 1'b1;
         cycle();
      end
      rand_in(1'b0); valid_in = 1'b1; freeze = 1'b1;
      cycle();
      chk("perf_retired_5", perf_retired, 32'd5);
      chk("perf_squashed_2", perf_squashed, 32'd2);
`endif

      for (int i = 0; i < 100; i++) begin
         rand_in(1'b1);
         cycle();
      end
      set_in(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
